// File: rtl/pu_or1k_pfpu32_addsub_rnd.sv
// pu_or1k_pfpu32_addsub_rnd
//   Normalise-and-round back end for the single-precision add/sub unit.
//   Two register stages, both gated by adv_i:
//     stage 1 : align the 28-bit fraction (carry right-shift or left-normalise)
//     stage 2 : round per rm_i, pack IEEE-754 result and exception flags
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   flush_i, adv_i    : clear valid bits / advance pipeline
//   rm_i              : rounding mode (00 RNE, 01 RTZ, 10 RUP, 11 RDN)
//   add_*_i           : add/sub stage result (sign, shift, exponents,
//                       fraction with carry/hidden/guard/round/sticky, specials)
//   rdy_o             : result valid
//   result_o          : IEEE-754 single result
//   inv_o..zero_o     : invalid, overflow, underflow, inexact, zero flags
module pu_or1k_pfpu32_addsub_rnd (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        adv_i,
  input  logic [1:0]  rm_i,
  input  logic        add_rdy_i,
  input  logic        add_sign_i,
  input  logic        add_sub_0_i,
  input  logic [4:0]  add_shl_i,
  input  logic [9:0]  add_exp10shl_i,
  input  logic [9:0]  add_exp10sh0_i,
  input  logic [27:0] add_fract28_i,
  input  logic        add_inv_i,
  input  logic        add_inf_i,
  input  logic        add_snan_i,
  input  logic        add_qnan_i,
  input  logic        add_anan_sign_i,
  output logic        rdy_o,
  output logic [31:0] result_o,
  output logic        inv_o,
  output logic        ovf_o,
  output logic        unf_o,
  output logic        inx_o,
  output logic        zero_o
);

  localparam int STAGES = 2;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  typedef struct packed {
    logic        sign;
    logic        sub_0;
    logic        inv;
    logic        inf;
    logic        snan;
    logic        qnan;
    logic        anan_sign;
    logic [1:0]  rm;
    logic [9:0]  exp;
    logic [27:0] fract;
  } s1_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1, s1_d;

  // ---------------------------------------------------------------- stage 1
  always_comb begin
    s1_d           = '0;
    s1_d.sign      = add_sign_i;
    s1_d.sub_0     = add_sub_0_i;
    s1_d.inv       = add_inv_i;
    s1_d.inf       = add_inf_i;
    s1_d.snan      = add_snan_i;
    s1_d.qnan      = add_qnan_i;
    s1_d.anan_sign = add_anan_sign_i;
    s1_d.rm        = rm_i;
    s1_d.fract     = add_fract28_i;
    s1_d.exp       = add_exp10sh0_i;
    if (add_fract28_i[27]) begin
      // carry out of the adder: drop one bit, folding it into sticky
      s1_d.fract = {1'b0, add_fract28_i[27:2], add_fract28_i[1] | add_fract28_i[0]};
      s1_d.exp   = add_exp10sh0_i + 10'd1;
    end else if (add_shl_i != 5'd0) begin
      s1_d.fract = add_fract28_i << add_shl_i;
      s1_d.exp   = add_exp10shl_i;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic        lsb, grd, rs, inx, roundup, inf_rnd, ovf;
  logic [24:0] m25;
  logic [23:0] mant;
  logic [9:0]  exp_r;
  logic [7:0]  exp_fld;

  assign lsb = s1.fract[3];
  assign grd = s1.fract[2];
  assign rs  = s1.fract[1] | s1.fract[0];
  assign inx = grd | rs;

  always_comb begin
    roundup = 1'b0;
    case (s1.rm)
      RM_RNE:  roundup = grd & (rs | lsb);
      RM_RTZ:  roundup = 1'b0;
      RM_RUP:  roundup = ~s1.sign & inx;
      default: roundup = s1.sign & inx;
    endcase
  end

  assign m25 = {1'b0, s1.fract[26:3]} + {24'd0, roundup};

  always_comb begin
    if (m25[24]) begin
      mant  = m25[24:1];
      exp_r = s1.exp + 10'd1;
    end else begin
      mant  = m25[23:0];
      exp_r = s1.exp;
    end
  end

  // hidden bit clear means denormal (or zero): exponent field is 0; a
  // denormal that rounds into the hidden bit picks up its exp of 1 here
  assign exp_fld = mant[23] ? exp_r[7:0] : 8'd0;
  assign ovf     = (exp_r >= 10'd255);
  assign inf_rnd = (s1.rm == RM_RNE) | ((s1.rm == RM_RUP) & ~s1.sign) |
                   ((s1.rm == RM_RDN) & s1.sign);

  logic [31:0] res_d;
  logic        inv_d, ovf_d, unf_d, inx_d, zero_d;

  always_comb begin
    res_d  = {s1.sign, exp_fld, mant[22:0]};
    inv_d  = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    inx_d  = 1'b0;
    zero_d = 1'b0;
    if (s1.inv) begin
      res_d = 32'h7FC0_0000;
      inv_d = 1'b1;
    end else if (s1.snan | s1.qnan) begin
      res_d = {s1.anan_sign, 8'hFF, 1'b1, 22'd0};
      inv_d = s1.snan;
    end else if (s1.inf) begin
      res_d = {s1.sign, 8'hFF, 23'd0};
    end else if (s1.sub_0) begin
      // exact cancellation: -0 only when rounding toward -inf
      res_d  = {(s1.rm == RM_RDN), 31'd0};
      zero_d = 1'b1;
    end else if (ovf) begin
      res_d = inf_rnd ? {s1.sign, 8'hFF, 23'd0} : {s1.sign, 8'hFE, 23'h7F_FFFF};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else begin
      inx_d  = inx;
      unf_d  = (exp_fld == 8'd0) & inx;
      zero_d = (exp_fld == 8'd0) & (mant[22:0] == 23'd0);
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      result_o <= '0;
      inv_o    <= 1'b0;
      ovf_o    <= 1'b0;
      unf_o    <= 1'b0;
      inx_o    <= 1'b0;
      zero_o   <= 1'b0;
    end else begin
      if (flush_i)
        vld_pipe <= '0;
      else if (adv_i)
        vld_pipe <= {vld_pipe[1], add_rdy_i};
      // data registers ignore flush; only the valid bits are cleared
      if (adv_i) begin
        s1       <= s1_d;
        result_o <= res_d;
        inv_o    <= inv_d;
        ovf_o    <= ovf_d;
        unf_o    <= unf_d;
        inx_o    <= inx_d;
        zero_o   <= zero_d;
      end
    end
  end

  assign rdy_o = vld_pipe[STAGES];

endmodule

// File: tb/tb_pu_or1k_pfpu32_addsub_rnd.sv
module tb_pu_or1k_pfpu32_addsub_rnd;

  typedef struct packed {
    logic        rdy;
    logic        sign;
    logic        sub0;
    logic [4:0]  shl;
    logic [9:0]  e_shl;
    logic [9:0]  e_sh0;
    logic [27:0] fract;
    logic        inv;
    logic        inf;
    logic        snan;
    logic        qnan;
    logic        asign;
    logic [1:0]  rm;
  } in_t;

  typedef struct packed {
    logic [31:0] result;
    logic        inv;
    logic        ovf;
    logic        unf;
    logic        inx;
    logic        zero;
  } out_t;

  logic clk = 1'b0;
  logic rst, flush, adv;
  in_t  din;

  logic        rdy_o;
  logic [31:0] result_o;
  logic        inv_o, ovf_o, unf_o, inx_o, zero_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pu_or1k_pfpu32_addsub_rnd dut (
    .clk(clk), .rst(rst), .flush_i(flush), .adv_i(adv), .rm_i(din.rm),
    .add_rdy_i(din.rdy), .add_sign_i(din.sign), .add_sub_0_i(din.sub0),
    .add_shl_i(din.shl), .add_exp10shl_i(din.e_shl), .add_exp10sh0_i(din.e_sh0),
    .add_fract28_i(din.fract), .add_inv_i(din.inv), .add_inf_i(din.inf),
    .add_snan_i(din.snan), .add_qnan_i(din.qnan), .add_anan_sign_i(din.asign),
    .rdy_o(rdy_o), .result_o(result_o), .inv_o(inv_o), .ovf_o(ovf_o),
    .unf_o(unf_o), .inx_o(inx_o), .zero_o(zero_o)
  );

  // Reference: treat the aligned fraction as an integer, keep the top 24
  // bits as the significand and round by comparing the dropped 3 bits
  // against one half.
  function automatic out_t model(in_t x);
    out_t o;
    longint unsigned n, q, rem;
    int e;
    bit inexact, up;
    o = '0;
    if (x.inv) begin
      o.result = 32'h7FC00000; o.inv = 1'b1;
    end else if (x.snan || x.qnan) begin
      o.result = {x.asign, 8'hFF, 1'b1, 22'd0}; o.inv = x.snan;
    end else if (x.inf) begin
      o.result = {x.sign, 8'hFF, 23'd0};
    end else if (x.sub0) begin
      o.result = {(x.rm == 2'd3), 31'd0}; o.zero = 1'b1;
    end else begin
      if (x.fract[27]) begin
        n = (longint'(x.fract) >> 1) | (longint'(x.fract) & 1);
        e = (int'(x.e_sh0) + 1) % 1024;
      end else if (x.shl != 0) begin
        n = (longint'(x.fract) << x.shl) & 64'hFFFFFFF;
        e = int'(x.e_shl);
      end else begin
        n = longint'(x.fract);
        e = int'(x.e_sh0);
      end
      q = (n >> 3) & 64'hFFFFFF;
      rem = n & 7;
      inexact = (rem != 0);
      case (x.rm)
        2'd0: up = (rem > 4) || (rem == 4 && q[0]);
        2'd1: up = 1'b0;
        2'd2: up = !x.sign && inexact;
        default: up = x.sign && inexact;
      endcase
      q = q + longint'(up);
      if (q >= 64'd16777216) begin q = q >> 1; e = (e + 1) % 1024; end
      if (e >= 255) begin
        o.ovf = 1'b1; o.inx = 1'b1;
        if (x.rm == 2'd0 || (x.rm == 2'd2 && !x.sign) || (x.rm == 2'd3 && x.sign))
          o.result = {x.sign, 8'hFF, 23'd0};
        else
          o.result = {x.sign, 8'hFE, 23'h7FFFFF};
      end else begin
        logic [7:0]  ef;
        logic [22:0] mf;
        ef = (q >= 64'd8388608) ? 8'(e) : 8'd0;
        mf = 23'(q);
        o.result = {x.sign, ef, mf};
        o.inx = inexact;
        o.unf = (ef == 0) && inexact;
        o.zero = (ef == 0) && (mf == 0);
      end
    end
    return o;
  endfunction

  // Pipeline bookkeeping for the reference: two adv-gated stages, flush
  // kills validity only.
  in_t  m_s1;
  logic m_v1, m_rdy;
  out_t m_out;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 <= '0; m_v1 <= 1'b0; m_rdy <= 1'b0; m_out <= '0;
    end else begin
      if (adv) begin
        m_out <= model(m_s1);
        m_s1  <= din;
      end
      if (flush) begin
        m_v1 <= 1'b0; m_rdy <= 1'b0;
      end else if (adv) begin
        m_v1 <= din.rdy; m_rdy <= m_v1;
      end
    end
  end

  // Scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      out_t got;
      got = '{result_o, inv_o, ovf_o, unf_o, inx_o, zero_o};
      checks++;
      if (rdy_o !== m_rdy || got !== m_out) begin
        errors++;
        $display("FAIL scoreboard t=%0t got rdy=%b res=%h flags(i,o,u,x,z)=%b%b%b%b%b want rdy=%b res=%h flags=%b%b%b%b%b",
                 $time, rdy_o, result_o, inv_o, ovf_o, unf_o, inx_o, zero_o,
                 m_rdy, m_out.result, m_out.inv, m_out.ovf, m_out.unf, m_out.inx, m_out.zero);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic in_t vec(input logic [27:0] f, input logic [9:0] e,
                              input logic s, input logic [1:0] rm);
    in_t v;
    v = '0; v.rdy = 1'b1; v.fract = f; v.e_sh0 = e; v.sign = s; v.rm = rm;
    return v;
  endfunction

  function automatic logic [36:0] pack(out_t o);
    return {o.result, o.inv, o.ovf, o.unf, o.inx, o.zero};
  endfunction

  task automatic rand_in();
    in_t v;
    int k;
    v = '0;
    v.rdy   = ($urandom_range(0, 9) < 7);
    v.sign  = 1'($urandom);
    v.rm    = 2'($urandom);
    v.fract = 28'($urandom);
    v.shl   = 5'd0;
    k = $urandom_range(0, 9);
    if (k < 3) begin
      v.fract[27] = 1'b0;
      v.shl = 5'($urandom_range(1, 26));
      v.fract = v.fract >> v.shl;
    end else if (k < 5) begin
      v.fract[27] = 1'b0;
    end else if (k == 5) begin
      v.fract = {2'b00, 23'h7FFFFF, 3'($urandom)};
    end
    k = $urandom_range(0, 3);
    v.e_sh0 = (k == 0) ? 10'd1 : (k == 1) ? 10'($urandom_range(250, 254))
                                          : 10'($urandom_range(1, 254));
    v.e_shl = 10'($urandom_range(0, 256));
    v.sub0  = ($urandom_range(0, 19) == 0);
    v.inv   = ($urandom_range(0, 29) == 0);
    v.inf   = ($urandom_range(0, 19) == 0);
    v.snan  = ($urandom_range(0, 29) == 0);
    v.qnan  = ($urandom_range(0, 29) == 0);
    v.asign = 1'($urandom);
    din = v;
  endtask

  initial begin
    // pin the reference model with hand-computed values
    chk("m_carry",  64'(pack(model(vec(28'h8000000, 10'd127, 1'b0, 2'd0)))), 64'({32'h40000000, 5'b00000}));
    chk("m_tie_rne", 64'(pack(model(vec(28'h400000C, 10'd127, 1'b0, 2'd0)))), 64'({32'h3F800002, 5'b00010}));
    chk("m_tie_rtz", 64'(pack(model(vec(28'h400000C, 10'd127, 1'b0, 2'd1)))), 64'({32'h3F800001, 5'b00010}));
    chk("m_ovf_rne", 64'(pack(model(vec(28'hFFFFFF8, 10'd254, 1'b0, 2'd0)))), 64'({32'h7F800000, 5'b01010}));
    chk("m_ovf_rtz", 64'(pack(model(vec(28'hFFFFFF8, 10'd254, 1'b0, 2'd1)))), 64'({32'h7F7FFFFF, 5'b01010}));
    chk("m_denorm_up", 64'(pack(model(vec(28'h3FFFFFC, 10'd1, 1'b0, 2'd0)))), 64'({32'h00800000, 5'b00010}));
    begin
      in_t v;
      v = vec(28'h0, 10'd0, 1'b0, 2'd3); v.sub0 = 1'b1;
      chk("m_sub0_rdn", 64'(pack(model(v))), 64'({32'h80000000, 5'b00001}));
      v.rm = 2'd0;
      chk("m_sub0_rne", 64'(pack(model(v))), 64'({32'h00000000, 5'b00001}));
      v = vec(28'h0, 10'd0, 1'b0, 2'd0); v.snan = 1'b1; v.asign = 1'b1;
      chk("m_snan", 64'(pack(model(v))), 64'({32'hFFC00000, 5'b10000}));
      v = vec(28'h0, 10'd0, 1'b0, 2'd0); v.inf = 1'b1;
      chk("m_inf", 64'(pack(model(v))), 64'({32'h7F800000, 5'b00000}));
    end

    // reset
    din = '0; flush = 1'b0; adv = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", 64'({rdy_o, result_o, inv_o, ovf_o, unf_o, inx_o, zero_o}), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // carry normalise, rdy two cycles later
    din = vec(28'h8000000, 10'd127, 1'b0, 2'd0);
    @(negedge clk); din.rdy = 1'b0;
    chk("carry_rdy_early", 64'(rdy_o), 64'd0);
    @(negedge clk);
    chk("carry_result", 64'({rdy_o, result_o, inv_o, ovf_o, unf_o, inx_o, zero_o}),
        64'({1'b1, 32'h40000000, 5'b00000}));

    // flush the cycle after launch
    din = vec(28'h400000C, 10'd127, 1'b0, 2'd0);
    @(negedge clk); din.rdy = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_no_rdy", 64'(rdy_o), 64'd0);
      @(negedge clk);
    end

    // adv low for 3 cycles freezes the pipe
    din = vec(28'h8000000, 10'd127, 1'b0, 2'd0);
    @(negedge clk); din = vec(28'h400000C, 10'd127, 1'b0, 2'd1); adv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("freeze_rdy", 64'(rdy_o), 64'd0);
    end
    adv = 1'b1;
    @(negedge clk); din.rdy = 1'b0;
    chk("freeze_release", 64'({rdy_o, result_o}), 64'({1'b1, 32'h40000000}));
    @(negedge clk);
    chk("rtz_tie", 64'({rdy_o, result_o, inx_o}), 64'({1'b1, 32'h3F800001, 1'b1}));

    // reset mid-pipe
    din = vec(28'hFFFFFF8, 10'd254, 1'b0, 2'd0);
    @(negedge clk); din.rdy = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_mid", 64'({rdy_o, result_o, inv_o, ovf_o, unf_o, inx_o, zero_o}), 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_rdy", 64'(rdy_o), 64'd0);
    end

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rand_in();
      adv   = ($urandom_range(0, 9) < 8);
      flush = ($urandom_range(0, 29) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0; flush = 1'b0; adv = 1'b1; din = '0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pu_or1k_pfpu32_addsub_rnd.md
PU_OR1K_PFPU32_ADDSUB_RND -- requirements
Module: pu_or1k_pfpu32_addsub_rnd

Interface
REQ-001 SHALL have: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset; one clock, synchronous, active-high.
REQ-003 SHALL have: flush_i  in  1  clears pipe valid bits; adv_i  in  1  advances pipe.
REQ-004 SHALL have: rm_i  in  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
REQ-005 SHALL have add/sub-stage result inputs:
- add_rdy_i 1; add_sign_i 1; add_sub_0_i 1.
- add_shl_i 5; add_exp10shl_i 10; add_exp10sh0_i 10.
- add_fract28_i 28: [27] carry, [26] hidden, [25:3] mantissa, [2] guard, [1] round, [0] sticky.
- add_inv_i, add_inf_i, add_snan_i, add_qnan_i, add_anan_sign_i, all 1.
REQ-006 SHALL have outputs:
- rdy_o 1; result_o 32 (IEEE-754 single).
- inv_o, ovf_o, unf_o, inx_o, zero_o, all 1.

Function
REQ-007 SHALL be two register stages, each updated only when adv_i=1; rdy_o asserts exactly two adv_i cycles after add_rdy_i is sampled.
REQ-008 Valid bits: on flush_i, cleared in the same cycle; flush_i has priority over adv_i. Data registers are not cleared by flush.
REQ-009 Stage 1 (align), in priority order:
- fract28[27]=1: shift right 1, new [0]=old[1]|old[0], exp=add_exp10sh0_i+1.
- else add_shl_i!=0: shift left by add_shl_i, exp=add_exp10shl_i.
- else: no shift, exp=add_exp10sh0_i.
Stage 1 SHALL also register sign, rm_i, and all special flags.
REQ-010 Stage 2 (round), with lsb=[3], g=[2], rs=[1]|[0]:
- inx=g|rs.
- roundup: RNE g&(rs|lsb); RTZ 0; RUP ~sign&inx; RDN sign&inx.
REQ-011 m25 = {0,[26:3]} + roundup.
- m25[24]=1: mantissa=m25[24:1], exp+1.
- else: mantissa=m25[23:0].
REQ-012 Exponent field = mantissa[23] ? exp[7:0] : 0.
- Covers denormals, where exp=1 and the hidden bit is 0.
- A denormal that rounds up into the hidden bit SHALL produce exp field 1.
REQ-013 Overflow: exp>=255 after rounding sets ovf_o=1 and inx_o=1.
- Result inf when RNE, RUP with sign 0, or RDN with sign 1.
- Otherwise result is max finite {sign,8'hFE,23'h7FFFFF}.
REQ-014 unf_o=1 iff exponent field is 0 and inx=1.
REQ-015 zero_o=1 iff result magnitude (exp field and mantissa) is 0.
REQ-016 Exact-zero subtraction (add_sub_0_i=1, no special flags): result {rm==RDN,31'd0}, zero_o=1, inx_o=0.
REQ-017 Special priority: inv > NaN > inf > normal.
- add_inv_i: result 32'h7FC00000, inv_o=1.
- snan|qnan: result {anan_sign,8'hFF,1'b1,22'd0}; inv_o=add_snan_i.
- inf: result {sign,8'hFF,23'd0}.
- All specials: ovf_o, unf_o, inx_o, zero_o = 0.
REQ-018 Outputs SHALL be registered and hold their value while adv_i=0.

Reset
REQ-019 On rst, all valid bits, rdy_o, result_o and all flags SHALL be 0 on the next edge.
REQ-020 rst asserted mid-operation SHALL discard in-flight results: no rdy_o pulse until new add_rdy_i data has advanced two stages.

Verification
REQ-021 Carry normalise: fract28=28'h8000000, exp10sh0=127, shl=0, RNE, adv held 1 -> result 32'h40000000, all flags 0, rdy_o two cycles later.
REQ-022 Tie rounding: fract28=28'h400000C, exp10sh0=127 -> RNE gives 32'h3F800002 with inx=1; RTZ gives 32'h3F800001 with inx=1.
REQ-023 Overflow: fract28=28'hFFFFFF8, exp10sh0=254, sign 0 -> RNE gives 32'h7F800000, ovf=1, inx=1; RTZ gives 32'h7F7FFFFF.
REQ-024 Zero and specials:
- sub_0 with RDN -> 32'h80000000, zero=1; with RNE -> 32'h00000000.
- snan with anan_sign=1 -> 32'hFFC00000, inv=1.
- inf with sign 0 -> 32'h7F800000.
REQ-025 Control:
- flush_i in the cycle after add_rdy_i -> rdy_o never pulses.
- adv_i=0 for 3 cycles -> outputs and pipe frozen.
- rst mid-pipe -> all outputs 0 next edge.
